// File: rtl/ram_pattern_player_if.sv
// ram_pattern_player_if: read-only pattern RAM port between the player and arbiter port 2
interface ram_pattern_player_if;
  logic        CTRL_CSb;
  logic        CTRL_WEb;
  logic [7:0]  CTRL_ADDR;
  logic [31:0] CTRL_DATA_IN;
  logic [31:0] CTRL_DATA_OUT;
  logic        ARB_BUSY;
  modport master (output CTRL_CSb, CTRL_WEb, CTRL_ADDR, CTRL_DATA_IN, input CTRL_DATA_OUT, ARB_BUSY);
  modport slave  (input CTRL_CSb, CTRL_WEb, CTRL_ADDR, CTRL_DATA_IN, output CTRL_DATA_OUT, ARB_BUSY);
endinterface

// File: rtl/ram_pattern_player.sv
// ram_pattern_player: fetches step words from pattern RAM and plays them onto GPIO_OUT
module ram_pattern_player #(
  parameter int GPIO_W = 16,
  parameter int CNT_W  = 14
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              START,
  input  logic              STOP,
  input  logic              LOOP_EN,
  input  logic [7:0]        START_ADDR,
  ram_pattern_player_if.master bus,
  output logic [GPIO_W-1:0] GPIO_OUT,
  output logic              STEP,
  output logic              RUNNING,
  output logic              DONE
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;
  typedef enum logic [1:0] {P_NONE, P_REQ, P_DAT, P_VAL} pf_t;
  state_t            state_q, state_d;
  pf_t               pf_q, pf_d;
  logic [7:0]        addr_q, addr_d, nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              end_q, end_d;
  logic [31:0]       buf_q, buf_d, ld_w;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              step_q, step_d, run_q, run_d, done_q, done_d, ld;
  logic              unused_ok;
  assign unused_ok = ^ld_w[30:GPIO_W+CNT_W];
  assign nxt = addr_q + 8'd4;
  always_comb begin
    state_d = state_q;
    pf_d    = pf_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    buf_d   = buf_q;
    gpio_d  = gpio_q;
    step_d  = 1'b0;
    run_d   = run_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_w    = bus.CTRL_DATA_OUT;
    case (state_q)
      IDLE:  if (START) begin
        addr_d  = {START_ADDR[7:2], 2'b00};
        run_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: if (!bus.ARB_BUSY) state_d = WAIT;
      WAIT:  begin
        ld      = 1'b1;
        state_d = PLAY;
      end
      PLAY:  begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (pf_q == P_REQ && !bus.ARB_BUSY) pf_d = P_DAT;
        if (pf_q == P_DAT) begin
          pf_d  = P_VAL;
          buf_d = bus.CTRL_DATA_OUT;
        end
        if (cnt_q == '0) begin
          if (end_q && LOOP_EN) begin
            addr_d  = {START_ADDR[7:2], 2'b00};
            state_d = FETCH;
          end else if (end_q) begin
            state_d = IDLE;
            run_d   = 1'b0;
            done_d  = 1'b1;
          end else if (pf_q == P_VAL || pf_q == P_DAT) begin
            // a stalled prefetch is loaded straight off the bus on its capture edge
            ld     = 1'b1;
            addr_d = nxt;
            ld_w   = pf_q == P_VAL ? buf_q : bus.CTRL_DATA_OUT;
          end
        end
      end
      default: ;
    endcase
    if (ld) begin
      gpio_d = ld_w[GPIO_W-1:0];
      cnt_d  = ld_w[GPIO_W +: CNT_W];
      end_d  = ld_w[31];
      step_d = 1'b1;
      pf_d   = ld_w[31] ? P_NONE : P_REQ;
    end
    if (STOP) begin
      state_d = IDLE;
      pf_d    = P_NONE;
      gpio_d  = gpio_q;
      step_d  = 1'b0;
      run_d   = 1'b0;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      pf_q    <= P_NONE;
      addr_q  <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
      buf_q   <= '0;
      gpio_q  <= '0;
      step_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      buf_q   <= buf_d;
      gpio_q  <= gpio_d;
      step_q  <= step_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end
  assign bus.CTRL_CSb     = !(state_q == FETCH || (state_q == PLAY && pf_q == P_REQ));
  assign bus.CTRL_ADDR    = state_q == PLAY ? nxt : addr_q;
  assign bus.CTRL_WEb     = 1'b1;
  assign bus.CTRL_DATA_IN = '0;
  assign GPIO_OUT         = gpio_q;
  assign STEP             = step_q;
  assign RUNNING          = run_q;
  assign DONE             = done_q;
endmodule
